// File: rtl/pe_stream_feeder.sv
// rtl/pe_stream_feeder.sv - operand burst driver and result collector for one systolic PE
module pe_stream_feeder #(
  parameter int DW      = 8,
  parameter int ACCW    = 32,
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            load_en,
  input  logic [AW-1:0]   load_addr,
  input  logic [DW-1:0]   load_w,
  input  logic [DW-1:0]   load_a,
  input  logic            start,
  input  logic [AW:0]     len,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [ACCW-1:0] result,
  output logic            pe_fire,
  output logic [DW-1:0]   pe_w,
  output logic [DW-1:0]   pe_a,
  input  logic            pe_out_f,
  input  logic [ACCW-1:0] pe_out
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = (AW + 1 > TW) ? AW + 1 : TW;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  state_t state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [AW:0]     len_q, len_n;
  logic            prev_f;
  logic            fire_n, busy_n, done_n, err_n;
  logic [DW-1:0]   w_n, a_n;
  logic [ACCW-1:0] result_n;
  logic [AW:0]     len_clamp;
  logic            can_load;

  logic [DW-1:0] w_mem [DEPTH];
  logic [DW-1:0] a_mem [DEPTH];

  assign can_load  = (state == IDLE) || (state == DONE);
  assign len_clamp = (len > DEPTH_L) ? DEPTH_L : len;

  // Operand storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (load_en && can_load) begin
      w_mem[load_addr] <= load_w;
      a_mem[load_addr] <= load_a;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      len_q   <= '0;
      prev_f  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      result  <= '0;
      pe_fire <= 1'b0;
      pe_w    <= '0;
      pe_a    <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      len_q   <= len_n;
      prev_f  <= pe_out_f;
      busy    <= busy_n;
      done    <= done_n;
      err     <= err_n;
      result  <= result_n;
      pe_fire <= fire_n;
      pe_w    <= w_n;
      pe_a    <= a_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    len_n    = len_q;
    fire_n   = 1'b0;
    w_n      = '0;
    a_n      = '0;
    done_n   = 1'b0;
    err_n    = err;
    result_n = result;
    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (start) begin
          result_n = '0;
          err_n    = 1'b0;
          cnt_n    = '0;
          if (len == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = STREAM;
            len_n   = len_clamp;
          end
        end
      end
      STREAM: begin
        // The buffer read lags the accepting edge by one cycle, so a load in the start cycle is seen.
        if (cnt < CW'(len_q)) begin
          fire_n = 1'b1;
          w_n    = w_mem[cnt[AW-1:0]];
          a_n    = a_mem[cnt[AW-1:0]];
          cnt_n  = cnt + CW'(1);
        end else begin
          state_n = DRAIN;
          cnt_n   = '0;
        end
      end
      DRAIN: begin
        if (prev_f && !pe_out_f) begin
          result_n = pe_out;
          done_n   = 1'b1;
          state_n  = DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == STREAM) || (state_n == DRAIN);
  end

endmodule

// File: tb/tb_pe_stream_feeder.sv
// tb/tb_pe_stream_feeder.sv - randomized self-checking bench for pe_stream_feeder
module tb_pe_stream_feeder;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [7:0]  load_w = '0, load_a = '0;
  logic        start = 1'b0;
  logic [4:0]  len = '0;
  logic        busy, done, err, pe_fire;
  logic [31:0] result;
  logic [7:0]  pe_w, pe_a;
  logic        pe_out_f;
  logic [31:0] pe_out;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0]  mw [16];
  logic [7:0]  ma [16];

  // Behavioural PE: accumulates w*a while fire is high, restarting on each new burst,
  // and forwards fire with a selectable delay.
  logic [7:0]  fire_sr;
  logic [31:0] acc;
  logic [2:0]  dsel = 3'd0;
  bit          hold_low = 1'b0;

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fire_sr <= '0;
      acc     <= '0;
    end else begin
      fire_sr <= {fire_sr[6:0], pe_fire};
      if (pe_fire) acc <= (fire_sr[0] ? acc : 32'd0) + 32'(pe_w) * 32'(pe_a);
    end
  end

  assign pe_out_f = hold_low ? 1'b0 : fire_sr[dsel];
  assign pe_out   = acc;

  pe_stream_feeder dut (
    .clk(clk), .rstn(rstn), .load_en(load_en), .load_addr(load_addr), .load_w(load_w),
    .load_a(load_a), .start(start), .len(len), .busy(busy), .done(done), .err(err),
    .result(result), .pe_fire(pe_fire), .pe_w(pe_w), .pe_a(pe_a), .pe_out_f(pe_out_f),
    .pe_out(pe_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic load(input int addr, input logic [7:0] w, input logic [7:0] a);
    load_en = 1'b1; load_addr = addr[3:0]; load_w = w; load_a = a;
    @(negedge clk);
    load_en = 1'b0;
    mw[addr] = w;
    ma[addr] = a;
  endtask

  // Called at a negedge. Expected timing: start edge E0; element k fires in the cycle after
  // edge k+1; done after edge n+2+d (PE forward delay d) or n+9 on drain timeout; 0 for len=0.
  task automatic run_burst(input int l, input int d, input bit tmo, input int inj,
                           input bit col, input logic [7:0] col_w, input bit b2b);
    int n, exp_done, nfire;
    logic [31:0] exp_sum;
    bit seen;
    dsel = 3'(d - 1);
    hold_low = tmo;
    if (col) begin
      load_en = 1'b1; load_addr = 4'd0; load_w = col_w; load_a = ma[0];
      mw[0] = col_w;
    end
    n = (l > 16) ? 16 : l;
    exp_sum = 32'd0;
    for (int k = 0; k < n; k++) exp_sum += 32'(mw[k]) * 32'(ma[k]);
    if (n == 0) exp_done = 0;
    else if (tmo) exp_done = n + 9;
    else exp_done = n + 2 + d;
    if (tmo) exp_sum = 32'd0;
    start = 1'b1;
    len = l[4:0];
    nfire = 0;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (i == 0 || i == inj + 1) begin
        start = 1'b0;
        load_en = 1'b0;
      end
      if (i == 0 && n > 0) check_eq("busy_after_start", busy, 1);
      if (pe_fire) begin
        check_eq("fire_pos", i, nfire + 1);
        if (nfire < 16) begin
          check_eq("pe_w", pe_w, mw[nfire]);
          check_eq("pe_a", pe_a, ma[nfire]);
        end
        nfire++;
      end
      if (done) begin
        seen = 1'b1;
        check_eq("done_cycle", i, exp_done);
        check_eq("err", err, tmo && n > 0);
        check_eq("result", result, exp_sum);
        check_eq("busy_in_done", busy, 0);
      end
      if (i == inj) begin
        start = 1'b1; len = 5'd3;
        load_en = 1'b1; load_addr = 4'd0; load_w = ~mw[0]; load_a = ~ma[0];
      end
    end
    check_eq("done_seen", seen, 1);
    check_eq("fire_count", nfire, n);
    if (!b2b) begin
      @(negedge clk);
      check_eq("done_one_cycle", done, 0);
    end
    hold_low = 1'b0;
  endtask

  initial begin
    bit seen_done, seen_act;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_fire", pe_fire, 0);
    check_eq("rst_w_a", {pe_w, pe_a}, 0);
    rstn = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 16; k++) load(k, 8'(k + 1), 8'd1);
    run_burst(16, 1, 0, -1, 0, 8'd0, 0);
    check_eq("result_136", result, 32'd136);
    run_burst(0, 1, 0, -1, 0, 8'd0, 0);
    run_burst(20, 2, 0, -1, 0, 8'd0, 0);
    run_burst(5, 1, 1, -1, 0, 8'd0, 0);
    run_burst(10, 1, 0, 3, 0, 8'd0, 0);
    run_burst(16, 3, 0, -1, 0, 8'd0, 0);
    run_burst(4, 1, 0, -1, 0, 8'd0, 1);
    run_burst(7, 4, 0, -1, 0, 8'd0, 0);
    run_burst(1, 1, 0, -1, 1, 8'd9, 0);

    start = 1'b1; len = 5'd16;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("fire_before_reset", pe_fire, 1);
    rstn = 1'b0;
    #1;
    check_eq("arst_fire", pe_fire, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_w_a", {pe_w, pe_a}, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    seen_done = 1'b0;
    seen_act = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
      if (busy || pe_fire) seen_act = 1'b1;
    end
    check_eq("no_done_after_reset", seen_done, 0);
    check_eq("idle_after_reset", seen_act, 0);

    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < 16; k++) load(k, 8'($urandom), 8'($urandom));
      run_burst(int'($urandom_range(0, 20)), int'($urandom_range(1, 4)),
                $urandom_range(0, 3) == 0, -1, 0, 8'd0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
